// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with a small {dp, nibble} register file.
// Each slot is BLANK (all digits off), then LATCH (decode captured), then SHOW (one digit lit).
module seg_scan_ctrl #(
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_idx,
  input  logic [3:0] wr_nibble,
  input  logic       wr_dp,
  output logic [6:0] segments,
  output logic       dp,
  output logic [3:0] digit_en,
  output logic       frame_done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_LATCH = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          frame_q, frame_d;
  logic          latch_en;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic [3:0]    rf_nib_q [4];
  logic          rf_dp_q  [4];
  logic          wr_fire;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Handshake: a write transfers on a rising edge where wr_valid && wr_ready.
  // wr_ready drops only in LATCH so the entry being decoded can never be torn.
  assign wr_ready = (state_q != ST_LATCH);
  assign wr_fire  = wr_valid && wr_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    frame_d  = 1'b0;
    latch_en = 1'b0;
    if (!ena) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = ST_LATCH;
        end
        ST_LATCH: begin
          cnt_d    = cnt_q + 1'b1;
          state_d  = ST_SHOW;
          latch_en = 1'b1;
        end
        ST_SHOW: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            frame_d = (idx_q == 2'd3);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        rf_nib_q[i] <= '0;
        rf_dp_q[i]  <= 1'b0;
      end
    end else if (wr_fire) begin
      rf_nib_q[wr_idx] <= wr_nibble;
      rf_dp_q[wr_idx]  <= wr_dp;
    end
  end

  // Segment pattern is frozen for the whole SHOW phase; later writes wait for the next LATCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= '0;
      dp_q  <= 1'b0;
    end else if (latch_en) begin
      seg_q <= hex7(rf_nib_q[idx_q]);
      dp_q  <= rf_dp_q[idx_q];
    end
  end

  assign segments   = seg_q;
  assign dp         = dp_q;
  assign digit_en   = (state_q == ST_SHOW) ? (4'b0001 << idx_q) : 4'b0000;
  assign frame_done = frame_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with PRESCALE=8, BLANK=2 (8-cycle slots, 32-cycle frames).
// Positions p count cycles from the first BLANK cycle of digit 0.
module tb_seg_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_idx;
  logic [3:0] wr_nibble;
  logic       wr_dp;
  logic [6:0] segments;
  logic       dp;
  logic [3:0] digit_en;
  logic       frame_done;
  logic [1:0] dbg_state;

  seg_scan_ctrl #(.PRESCALE(8), .BLANK(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_idx     (wr_idx),
    .wr_nibble  (wr_nibble),
    .wr_dp      (wr_dp),
    .segments   (segments),
    .dp         (dp),
    .digit_en   (digit_en),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t limit reached", $time);
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    int         p;
    logic [1:0] idx;
    logic [3:0] nib;
    logic       dp;
  } wr_t;

  wr_t        wq [$];
  logic [3:0] rf_nib [4];
  logic       rf_dp  [4];
  logic [3:0] sh_nib [4];
  logic       sh_dp  [4];

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      rf_nib[i] = '0;
      rf_dp[i]  = 1'b0;
      sh_nib[i] = '0;
      sh_dp[i]  = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_seg"},   segments,   7'h00);
    check_eq({tag, "_dp"},    dp,         1'b0);
    check_eq({tag, "_den"},   digit_en,   4'b0000);
    check_eq({tag, "_fd"},    frame_done, 1'b0);
    check_eq({tag, "_rdy"},   wr_ready,   1'b1);
    check_eq({tag, "_state"}, dbg_state,  2'd0);
  endtask

  // Advance from position p_from-1 to p_to, applying queued writes and checking every cycle.
  task automatic run(input int p_from, input int p_to);
    int   q, d, s;
    logic drv, exp_rdy;
    for (int p = p_from; p <= p_to; p++) begin
      drv     = (wq.size() > 0) && (wq[0].p <= p);
      exp_rdy = (((p - 1) % 8) != 2);
      if (drv) begin
        wr_valid  = 1'b1;
        wr_idx    = wq[0].idx;
        wr_nibble = wq[0].nib;
        wr_dp     = wq[0].dp;
        check_eq($sformatf("wr_ready_pre@%0d", p), wr_ready, exp_rdy);
      end else begin
        wr_valid = 1'b0;
      end
      @(negedge clk);
      if (drv && exp_rdy) begin
        rf_nib[wq[0].idx] = wq[0].nib;
        rf_dp[wq[0].idx]  = wq[0].dp;
        void'(wq.pop_front());
      end
      q = p % 32;
      d = q / 8;
      s = q % 8;
      if (s == 3) begin
        sh_nib[d] = rf_nib[d];
        sh_dp[d]  = rf_dp[d];
      end
      check_eq($sformatf("digit_en@%0d", p), digit_en, (s < 3) ? 4'b0000 : (4'b0001 << d));
      check_eq($sformatf("frame_done@%0d", p), frame_done, (q == 0));
      check_eq($sformatf("wr_ready@%0d", p), wr_ready, (s != 2));
      if (s >= 3) begin
        check_eq($sformatf("segments@%0d", p), segments, seg_tab[sh_nib[d]]);
        check_eq($sformatf("dp@%0d", p), dp, sh_dp[d]);
      end
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b1;
    wr_valid  = 1'b0;
    wr_idx    = '0;
    wr_nibble = '0;
    wr_dp     = 1'b0;
    clear_model();
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // idle frames: 0 shown everywhere, frame_done at cycle 32
    run(1, 32);
    run(1, 32);

    // digit 2 = A with decimal point
    wq.push_back('{1, 2'd2, 4'hA, 1'b1});
    run(1, 32);
    run(1, 32);

    // write held across LATCH of digit 1, write into the shown digit, back-to-back writes to digit 3
    wq.push_back('{11, 2'd1, 4'h5, 1'b0});
    wq.push_back('{20, 2'd3, 4'h1, 1'b0});
    wq.push_back('{21, 2'd3, 4'hC, 1'b1});
    run(1, 32);
    run(1, 32);

    // every hex value through the decoder
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++)
        wq.push_back('{i + 1, 2'(i), 4'(4 * k + i), (i == k)});
      run(1, 32);
    end

    // ena dropped in the 3rd SHOW cycle of digit 1, with a write while parked
    run(1, 13);
    for (int c = 0; c < 3; c++) begin
      ena = 1'b0;
      if (c == 0) begin
        wr_valid  = 1'b1;
        wr_idx    = 2'd1;
        wr_nibble = 4'h9;
        wr_dp     = 1'b1;
        check_eq("dis_wr_ready_pre", wr_ready, 1'b1);
      end else begin
        wr_valid = 1'b0;
      end
      @(negedge clk);
      if (c == 0) begin
        rf_nib[1] = 4'h9;
        rf_dp[1]  = 1'b1;
      end
      check_eq($sformatf("dis_digit_en%0d", c), digit_en, 4'b0000);
      check_eq($sformatf("dis_frame_done%0d", c), frame_done, 1'b0);
      check_eq($sformatf("dis_wr_ready%0d", c), wr_ready, 1'b1);
    end
    wr_valid = 1'b0;
    ena      = 1'b1;
    run(9, 32);
    run(1, 32);

    // reset mid-LATCH of digit 2 clears everything and restarts at digit 0
    run(1, 18);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    clear_model();
    rst_n = 1'b1;
    run(1, 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 1000: total clock cycles per digit slot; legal range PRESCALE >= BLANK+2.
REQ-002 SHALL have parameter BLANK, default 4: all-digits-off cycles at the start of each slot (anti-ghosting); legal range BLANK >= 1.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 ena  in  1  design enable; low blanks the display and parks the scan.
REQ-006 wr_valid  in  1  write request for one digit register.
REQ-007 wr_ready  out  1  write may be accepted this cycle.
REQ-008 wr_idx  in  2  target digit 0..3.
REQ-009 wr_nibble  in  4  hex value 0x0..0xF.
REQ-010 wr_dp  in  1  decimal point for the target digit.
REQ-011 segments  out  7  active-high; bit0=a ... bit6=g.
REQ-012 dp  out  1  active-high decimal point.
REQ-013 digit_en  out  4  one-hot active-high digit select; all-zero when blank.
REQ-014 frame_done  out  1  one-cycle pulse per completed 4-digit scan.

Function
REQ-015 SHALL hold a 4-entry register file of {dp, nibble}; a write is accepted on the rising edge where wr_valid && wr_ready; entry wr_idx takes {wr_dp, wr_nibble}.
REQ-016 SHALL implement FSM BLANK -> LATCH -> SHOW -> BLANK, with a slot counter and a 2-bit digit index.
REQ-017 BLANK: lasts exactly BLANK cycles; digit_en=0000.
REQ-018 LATCH: lasts exactly 1 cycle; digit_en=0000; wr_ready=0; captures the hex decode of entry[digit index] into the segments/dp output registers.
REQ-019 SHOW: lasts exactly PRESCALE-BLANK-1 cycles; digit_en=one-hot(digit index); segments/dp stable throughout.
REQ-020 On SHOW exit, the digit index SHALL increment mod 4; the slot period is PRESCALE cycles and the frame period is 4*PRESCALE cycles.
REQ-021 frame_done SHALL be 1 in the first BLANK cycle following SHOW of digit 3 (index wrap 3->0), and 0 in all other cycles.
REQ-022 wr_ready SHALL be 1 in every state except LATCH; a write is never lost or torn.
REQ-023 A write to the digit currently in SHOW SHALL NOT change the outputs until that digit's next LATCH.
REQ-024 Hex decode, gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-025 ena=0 at an edge SHALL force state BLANK, slot counter 0, digit_en=0000 and frame_done=0; the digit index and register file are held; writes are still accepted.
REQ-026 On ena returning to 1, the scan SHALL restart with a full BLANK phase of the held digit index.
REQ-027 Simultaneous writes to the same entry in consecutive cycles SHALL take the last accepted value.

Reset
REQ-028 rst_n=0 at a rising edge SHALL set state BLANK, slot counter 0, digit index 0, all register-file entries {0,0x0}, segments=0000000, dp=0, digit_en=0000, frame_done=0.
REQ-029 After the reset edge, wr_ready SHALL read 1 (state BLANK).
REQ-030 Reset asserted mid-SHOW or mid-LATCH SHALL take effect at that edge and discard the in-flight slot; register-file contents are cleared.

Verification (PRESCALE=8, BLANK=2)
REQ-031 Reset, ena=1, no writes:
- digit_en = 0000 for 3 cycles, then 0001 for 5 cycles, then 0000 for 3 cycles, then 0010.
- segments=3F in every SHOW cycle.
REQ-032 Write idx2=0xA, dp=1:
- during the digit_en=0100 window: segments=77, dp=1.
- other digits: segments=3F, dp=0.
REQ-033 frame_done:
- pulses exactly once every 32 cycles.
- first pulse 32 cycles after reset release.
- never two consecutive 1s.
REQ-034 wr_valid held during a LATCH cycle:
- wr_ready=0 in that cycle, so the entry is unchanged.
- the write is accepted on the next cycle, when wr_ready=1.
REQ-035 ena dropped in the 3rd SHOW cycle of digit 1:
- digit_en=0000 on the next edge.
- on re-enable: 2 BLANK cycles + 1 LATCH, then digit_en=0010 for 5 cycles.
REQ-036 rst_n pulsed low for 1 cycle mid-frame after writes:
- all outputs are zero after that edge.
- the scan restarts at digit 0 showing 3F.
